// File: rtl/cubic_sweep_driver_if.sv
// AXI-Stream link carrying 32-bit samples between the sweep driver and the cubic pipeline.
interface axi_stream_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cubic_sweep_driver.sv
// Emits a frame of abscissae START + i*STEP toward the cubic pipeline and collects
// the results into a count and a wrap-around checksum, with a credit limit on in-flight samples.
module cubic_sweep_driver #(
    parameter logic signed [31:0] START           = 32'sd0,
    parameter logic signed [31:0] STEP            = 32'sd1,
    parameter logic        [15:0] COUNT           = 16'd16,
    parameter logic        [7:0]  MAX_OUTSTANDING = 8'd4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    axi_stream_if.master        src,
    axi_stream_if.slave         snk,
    output logic                busy,
    output logic                done,
    output logic [15:0]         rx_count,
    output logic [31:0]         checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] tx_idx_r;
    logic [7:0]  outstanding_r;

    logic        src_hs_s;
    logic        snk_hs_s;
    logic        more_s;
    logic        credit_s;
    logic [15:0] tx_idx_nxt_s;
    logic [15:0] rx_nxt_s;
    logic [7:0]  out_nxt_s;
    logic [31:0] data_nxt_s;
    logic [31:0] sum_nxt_s;
    logic        unused_tlast_s;

    // The pipeline never marks frame ends on its output, so its TLAST carries no information.
    assign unused_tlast_s = snk.tlast;

    // Post-handshake values of the counters; a return at zero credit saturates rather than wraps
    always_comb begin
        src_hs_s = src.tvalid && src.tready;
        snk_hs_s = snk.tvalid && snk.tready;

        if (src_hs_s) begin
            tx_idx_nxt_s = tx_idx_r + 16'd1;
            data_nxt_s   = src.tdata + STEP;
        end else begin
            tx_idx_nxt_s = tx_idx_r;
            data_nxt_s   = src.tdata;
        end

        if (snk_hs_s) begin
            rx_nxt_s  = rx_count + 16'd1;
            sum_nxt_s = checksum + snk.tdata;
        end else begin
            rx_nxt_s  = rx_count;
            sum_nxt_s = checksum;
        end

        if (src_hs_s && !snk_hs_s) begin
            out_nxt_s = outstanding_r + 8'd1;
        end else if (snk_hs_s && !src_hs_s && (outstanding_r != 8'd0)) begin
            out_nxt_s = outstanding_r - 8'd1;
        end else begin
            out_nxt_s = outstanding_r;
        end

        more_s   = (tx_idx_nxt_s < COUNT);
        credit_s = (out_nxt_s < MAX_OUTSTANDING);
    end

    // Sweep FSM driving every stream and status output from registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            tx_idx_r      <= 16'd0;
            outstanding_r <= 8'd0;
            src.tvalid    <= 1'b0;
            src.tdata     <= 32'd0;
            src.tlast     <= 1'b0;
            snk.tready    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rx_count      <= 16'd0;
            checksum      <= 32'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        tx_idx_r      <= 16'd0;
                        outstanding_r <= 8'd0;
                        rx_count      <= 16'd0;
                        checksum      <= 32'd0;
                        if (COUNT == 16'd0) begin
                            state_r    <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            src.tvalid <= 1'b0;
                            snk.tready <= 1'b0;
                        end else begin
                            state_r    <= SEND;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            src.tvalid <= 1'b1;
                            src.tdata  <= START;
                            src.tlast  <= (COUNT == 16'd1);
                            snk.tready <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                SEND, DRAIN: begin
                    tx_idx_r      <= tx_idx_nxt_s;
                    outstanding_r <= out_nxt_s;
                    rx_count      <= rx_nxt_s;
                    checksum      <= sum_nxt_s;
                    src.tdata     <= data_nxt_s;
                    src.tlast     <= (tx_idx_nxt_s == (COUNT - 16'd1));
                    // A beat still waiting for TREADY stays up regardless of credit.
                    if (src.tvalid && !src.tready) begin
                        src.tvalid <= 1'b1;
                    end else begin
                        src.tvalid <= more_s && credit_s;
                    end
                    if (!more_s && (rx_nxt_s >= COUNT)) begin
                        state_r    <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        src.tvalid <= 1'b0;
                        snk.tready <= 1'b0;
                    end else if (!more_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    src.tvalid <= 1'b0;
                    snk.tready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cubic_sweep_driver.sv
// Directed bench: five driver instances with different parameters, each fed by a
// zero-latency model of the cubic pipeline (f(x) = x^3 + x^2 + x + 1).
module tb_cubic_sweep_driver;

    localparam int N = 5;
    localparam logic signed [31:0] P_START [N] = '{32'sd0, 32'sd0, 32'sd0, 32'sd5, 32'sd0};
    localparam logic signed [31:0] P_STEP  [N] = '{32'sd1, 32'sd1, 32'sd1, -32'sd3, 32'sd1};
    localparam logic [15:0]        P_COUNT [N] = '{16'd4, 16'd0, 16'd4, 16'd4, 16'd8};
    localparam logic [7:0]         P_MAX   [N] = '{8'd4, 8'd4, 8'd2, 8'd4, 8'd4};

    logic        clk;
    logic        rst;
    logic        start     [N];
    logic        src_ready [N];
    logic        snk_en    [N];
    logic        src_valid [N];
    logic [31:0] src_data  [N];
    logic        src_last  [N];
    logic        snk_valid [N];
    logic [31:0] snk_data  [N];
    logic        snk_ready [N];
    logic        busy      [N];
    logic        done      [N];
    logic [15:0] rx_count  [N];
    logic [31:0] checksum  [N];

    logic [31:0] pipe_q [N][$];
    logic [31:0] sent_q [N][$];
    logic        last_q [N][$];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        axi_stream_if src_if ();
        axi_stream_if snk_if ();

        assign src_if.tready = src_ready[g];
        assign src_valid[g]  = src_if.tvalid;
        assign src_data[g]   = src_if.tdata;
        assign src_last[g]   = src_if.tlast;
        assign snk_if.tvalid = snk_valid[g];
        assign snk_if.tdata  = snk_data[g];
        assign snk_if.tlast  = 1'b0;
        assign snk_ready[g]  = snk_if.tready;

        cubic_sweep_driver #(
            .START(P_START[g]), .STEP(P_STEP[g]), .COUNT(P_COUNT[g]), .MAX_OUTSTANDING(P_MAX[g])
        ) u_dut (
            .clk(clk), .rst(rst), .start(start[g]), .src(src_if), .snk(snk_if),
            .busy(busy[g]), .done(done[g]), .rx_count(rx_count[g]), .checksum(checksum[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] horner(input logic [31:0] x);
        return x * x * x + x * x + x + 32'd1;
    endfunction

    // Pipeline model: results queue up in order and are offered whenever the sink is enabled.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                pipe_q[k].delete();
                sent_q[k].delete();
                last_q[k].delete();
            end else begin
                if (snk_valid[k] && snk_ready[k]) void'(pipe_q[k].pop_front());
                if (src_valid[k] && src_ready[k]) begin
                    sent_q[k].push_back(src_data[k]);
                    last_q[k].push_back(src_last[k]);
                    pipe_q[k].push_back(horner(src_data[k]));
                end
            end
            snk_valid[k] <= !rst && snk_en[k] && (pipe_q[k].size() > 0);
            snk_data[k]  <= (pipe_q[k].size() > 0) ? pipe_q[k][0] : 32'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int c = 0;
        while (!done[k] && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_within_budget", 32'(done[k]), 32'd1);
    endtask

    task automatic wait_sent(input int k, input int n, input int budget);
        int c = 0;
        while (sent_q[k].size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("sent_within_budget", 32'(sent_q[k].size()), 32'(n));
    endtask

    task automatic check_reset(input int k);
        check("rst_src_valid", 32'(src_valid[k]), 32'd0);
        check("rst_src_data",  src_data[k],       32'd0);
        check("rst_src_last",  32'(src_last[k]),  32'd0);
        check("rst_snk_ready", 32'(snk_ready[k]), 32'd0);
        check("rst_busy",      32'(busy[k]),      32'd0);
        check("rst_done",      32'(done[k]),      32'd0);
        check("rst_rx_count",  32'(rx_count[k]),  32'd0);
        check("rst_checksum",  checksum[k],       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [4];
        logic pv, pr, pl;
        logic [31:0] pd;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            start[k]     = 1'b0;
            src_ready[k] = 1'b1;
            snk_en[k]    = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset(0);

        // Basic frame 0..3 with everything ready.
        pulse_start(0);
        check("t1_first_valid", 32'(src_valid[0]), 32'd1);
        check("t1_first_data",  src_data[0],       32'd0);
        check("t1_busy",        32'(busy[0]),      32'd1);
        wait_done(0, 40);
        check("t1_sent_n",  32'(sent_q[0].size()), 32'd4);
        check("t1_sent_0",  sent_q[0][0], 32'd0);
        check("t1_sent_3",  sent_q[0][3], 32'd3);
        check("t1_last_2",  32'(last_q[0][2]), 32'd0);
        check("t1_last_3",  32'(last_q[0][3]), 32'd1);
        check("t1_rx",      32'(rx_count[0]), 32'd4);
        check("t1_sum",     checksum[0], 32'd60);
        check("t1_busy_lo", 32'(busy[0]), 32'd0);
        check("t1_src_idle", 32'(src_valid[0]), 32'd0);
        check("t1_snk_idle", 32'(snk_ready[0]), 32'd0);

        // Start during DRAIN is ignored, start in DONE relaunches.
        snk_en[0] = 1'b0;
        pulse_start(0);
        repeat (8) @(negedge clk);
        check("t6_drain_busy", 32'(busy[0]), 32'd1);
        check("t6_drain_rx",   32'(rx_count[0]), 32'd0);
        pulse_start(0);
        check("t6_ign_busy",  32'(busy[0]), 32'd1);
        check("t6_ign_valid", 32'(src_valid[0]), 32'd0);
        check("t6_ign_sum",   checksum[0], 32'd0);
        snk_en[0] = 1'b1;
        wait_done(0, 40);
        check("t6_rx",  32'(rx_count[0]), 32'd4);
        check("t6_sum", checksum[0], 32'd60);
        pulse_start(0);
        check("t6_re_rx",    32'(rx_count[0]), 32'd0);
        check("t6_re_sum",   checksum[0], 32'd0);
        check("t6_re_done",  32'(done[0]), 32'd0);
        check("t6_re_valid", 32'(src_valid[0]), 32'd1);
        check("t6_re_data",  src_data[0], 32'd0);
        wait_done(0, 40);
        check("t6_re_final_sum", checksum[0], 32'd60);

        // Empty frame goes straight to DONE.
        pulse_start(1);
        check("t2_done",  32'(done[1]), 32'd1);
        check("t2_busy",  32'(busy[1]), 32'd0);
        repeat (4) @(negedge clk);
        check("t2_no_tx", 32'(sent_q[1].size()), 32'd0);
        check("t2_rx",    32'(rx_count[1]), 32'd0);
        check("t2_sum",   checksum[1], 32'd0);

        // Credit window of 2 with a stalled result stream.
        snk_en[2] = 1'b0;
        pulse_start(2);
        repeat (20) @(negedge clk);
        check("t3_sent_n", 32'(sent_q[2].size()), 32'd2);
        check("t3_valid",  32'(src_valid[2]), 32'd0);
        check("t3_data",   src_data[2], 32'd2);
        snk_en[2] = 1'b1;
        @(negedge clk);
        check("t3_still_2", 32'(sent_q[2].size()), 32'd2);
        @(negedge clk);
        check("t3_rx1",     32'(rx_count[2]), 32'd1);
        check("t3_resume",  32'(src_valid[2]), 32'd1);
        check("t3_res_data", src_data[2], 32'd2);
        wait_done(2, 40);
        check("t3_sum", checksum[2], 32'd60);

        // Toggled TREADY with a negative step: beats must hold while stalled.
        start[3] = 1'b1;
        for (int i = 0; i < 40 && !done[3]; i++) begin
            src_ready[3] = pat[i % 4];
            pv = src_valid[3];
            pr = src_ready[3];
            pd = src_data[3];
            pl = src_last[3];
            @(negedge clk);
            start[3] = 1'b0;
            if (pv && !pr) begin
                check("t4_hold_data", src_data[3], pd);
                check("t4_hold_last", 32'(src_last[3]), 32'(pl));
            end
        end
        src_ready[3] = 1'b1;
        wait_done(3, 10);
        check("t4_sent_n", 32'(sent_q[3].size()), 32'd4);
        check("t4_sent_0", sent_q[3][0], 32'd5);
        check("t4_sent_1", sent_q[3][1], 32'd2);
        check("t4_sent_2", sent_q[3][2], 32'hFFFF_FFFF);
        check("t4_sent_3", sent_q[3][3], 32'hFFFF_FFFC);
        check("t4_last_3", 32'(last_q[3][3]), 32'd1);
        check("t4_sum",    checksum[3], 32'd120);

        // Reset after the second beat of an 8-sample frame, then replay.
        pulse_start(4);
        wait_sent(4, 2, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset(4);
        pulse_start(4);
        check("t5_replay_valid", 32'(src_valid[4]), 32'd1);
        check("t5_replay_data",  src_data[4], 32'd0);
        check("t5_replay_rx",    32'(rx_count[4]), 32'd0);
        wait_done(4, 60);
        check("t5_sent_n", 32'(sent_q[4].size()), 32'd8);
        check("t5_rx",     32'(rx_count[4]), 32'd8);
        check("t5_sum",    checksum[4], 32'd960);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
